// File: rtl/cga_pixel_serializer.sv
// CGA pixel serializer: byte FIFO feeding an MSB-first shifter (1/2/4 bpp) and a 16-entry palette.
// Video is registered one clk after each pix_ce; FIFO starvation raises a sticky underflow flag.
module cga_pixel_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_BITS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic                pix_ce,
  input  logic [1:0]          bpp_sel,
  input  logic                display_enable,
  input  logic [OUT_BITS-1:0] border_col,
  input  logic                pal_we,
  input  logic [3:0]          pal_addr,
  input  logic [OUT_BITS-1:0] pal_data,
  input  logic                clr_underflow,
  output logic [OUT_BITS-1:0] video,
  output logic                underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [7:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, push, pop;

  logic [7:0]          shreg;
  logic [3:0]          cnt;
  logic [1:0]          bpp_lat;
  logic [OUT_BITS-1:0] pal [16];

  logic                active, exhausted, load, starve, emit;
  logic [7:0]          src_byte;
  logic [1:0]          src_bpp;
  logic [3:0]          pix_idx;
  logic [2:0]          shift_amt;
  logic [3:0]          ppb;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign byte_ready = !full;

  assign active    = pix_ce && display_enable;
  assign exhausted = (cnt == 4'd0);
  assign load      = active && exhausted && !empty;
  assign starve    = active && exhausted && empty;
  assign emit      = active && !starve;
  assign pop       = load;
  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign push      = byte_valid && (!full || pop);

  always_comb begin
    src_byte  = load ? mem[rd_ptr] : shreg;
    src_bpp   = load ? bpp_sel : bpp_lat;
    pix_idx   = {3'b000, src_byte[7]};
    shift_amt = 3'd1;
    ppb       = 4'd8;
    case (src_bpp)
      2'd1: begin
        pix_idx   = {2'b00, src_byte[7:6]};
        shift_amt = 3'd2;
        ppb       = 4'd4;
      end
      2'd2: begin
        pix_idx   = src_byte[7:4];
        shift_amt = 3'd4;
        ppb       = 4'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      cnt     <= '0;
      bpp_lat <= '0;
      video   <= '0;
    end else if (pix_ce) begin
      if (!display_enable) begin
        cnt <= '0;
      end else if (emit) begin
        shreg <= src_byte << shift_amt;
        cnt   <= load ? ppb - 4'd1 : cnt - 4'd1;
        if (load) bpp_lat <= bpp_sel;
      end
      // Palette read sees the pre-write value when pal_we targets the same entry.
      video <= emit ? pal[pix_idx] : border_col;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (starve) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) pal[i] <= OUT_BITS'(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

endmodule

// File: tb/tb_cga_pixel_serializer.sv
// Directed bench for cga_pixel_serializer: expected video values are queued as pix_ce is driven
// and compared one clk later; flags and byte_ready are checked at fixed points.
module tb_cga_pixel_serializer;

  localparam int OB = 4;
  localparam logic [OB-1:0] BORDER = 4'h9;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          pix_ce;
  logic [1:0]    bpp_sel;
  logic          display_enable;
  logic [OB-1:0] border_col;
  logic          pal_we;
  logic [3:0]    pal_addr;
  logic [OB-1:0] pal_data;
  logic          clr_underflow;
  logic [OB-1:0] video;
  logic          underflow;

  int total = 0;
  int bad   = 0;
  logic [OB-1:0] exp_q[$];
  logic [OB-1:0] pal_m [16];
  logic [OB-1:0] last_exp;

  cga_pixel_serializer #(.FIFO_DEPTH(4), .OUT_BITS(OB)) dut (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .pix_ce(pix_ce), .bpp_sel(bpp_sel),
    .display_enable(display_enable), .border_col(border_col), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .clr_underflow(clr_underflow),
    .video(video), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic was_ce;
    was_ce = pix_ce;
    @(posedge clk);
    #1;
    if (was_ce) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 8'd1, 8'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("video", {4'b0, video}, {4'b0, last_exp});
      end
    end
    pix_ce        = 1'b0;
    byte_valid    = 1'b0;
    pal_we        = 1'b0;
    clr_underflow = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    step();
  endtask

  task automatic pix(input logic de, input logic [OB-1:0] e);
    display_enable = de;
    pix_ce         = 1'b1;
    exp_q.push_back(e);
    step();
  endtask

  task automatic pal_reset_model();
    for (int i = 0; i < 16; i++) pal_m[i] = OB'(i);
  endtask

  initial begin
    logic [7:0] bytes [4];
    reset = 1'b1; byte_data = '0; byte_valid = 1'b0; pix_ce = 1'b0; bpp_sel = 2'd0;
    display_enable = 1'b1; border_col = BORDER; pal_we = 1'b0; pal_addr = '0;
    pal_data = '0; clr_underflow = 1'b0; last_exp = '0;
    pal_reset_model();

    // Reset state
    #12;
    check("rst_byte_ready", {7'b0, byte_ready}, 8'd1);
    check("rst_video", {4'b0, video}, 8'd0);
    check("rst_underflow", {7'b0, underflow}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1bpp identity on 0xA5
    push_byte(8'hA5);
    for (int b = 7; b >= 0; b--) begin
      bytes[0] = 8'hA5;
      pix(1'b1, pal_m[{3'b0, bytes[0][b]}]);
    end
    check("a5_no_underflow", {7'b0, underflow}, 8'd0);

    // 2bpp with a mid-byte depth change
    bpp_sel = 2'd1;
    push_byte(8'hE4);
    push_byte(8'h1B);
    pix(1'b1, pal_m[3]);
    pix(1'b1, pal_m[2]);
    bpp_sel = 2'd2;
    pix(1'b1, pal_m[1]);
    pix(1'b1, pal_m[0]);
    pix(1'b1, pal_m[1]);
    pix(1'b1, pal_m[11]);

    // Palette write colliding with a lookup of the same entry
    push_byte(8'h55);
    pal_we = 1'b1; pal_addr = 4'd5; pal_data = 4'hC;
    pix(1'b1, pal_m[5]);
    pal_m[5] = 4'hC;
    pix(1'b1, pal_m[5]);

    // Fill, overflow drop, drain, underflow
    bpp_sel = 2'd0;
    bytes[0] = 8'h0F; bytes[1] = 8'hF0; bytes[2] = 8'h3C; bytes[3] = 8'h81;
    for (int k = 0; k < 4; k++) push_byte(bytes[k]);
    check("full_byte_ready", {7'b0, byte_ready}, 8'd0);
    push_byte(8'hFF);
    check("drop_byte_ready", {7'b0, byte_ready}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      for (int b = 7; b >= 0; b--) begin
        pix(1'b1, pal_m[{3'b0, bytes[k][b]}]);
        if (k == 0 && b == 7) check("pop_byte_ready", {7'b0, byte_ready}, 8'd1);
      end
    end
    check("drained_no_underflow", {7'b0, underflow}, 8'd0);
    pix(1'b1, BORDER);
    check("underflow_set", {7'b0, underflow}, 8'd1);
    clr_underflow = 1'b1;
    pix(1'b1, BORDER);
    check("underflow_set_wins", {7'b0, underflow}, 8'd1);
    clr_underflow = 1'b1;
    step();
    check("underflow_cleared", {7'b0, underflow}, 8'd0);

    // Blanking discards the rest of the byte
    push_byte(8'hFF);
    push_byte(8'h00);
    for (int k = 0; k < 3; k++) pix(1'b1, pal_m[1]);
    pix(1'b0, BORDER);
    check("blank_no_underflow", {7'b0, underflow}, 8'd0);
    pix(1'b1, pal_m[0]);
    pix(1'b0, BORDER);

    // No pix_ce: pushes proceed, video holds
    pix(1'b1, BORDER);
    check("underflow_again", {7'b0, underflow}, 8'd1);
    push_byte(8'hAA);
    step();
    check("video_hold", {4'b0, video}, {4'b0, last_exp});
    pix(1'b1, pal_m[1]);
    push_byte(8'h12);
    push_byte(8'h34);

    // Async reset between edges, mid-byte with buffered data
    #3;
    reset = 1'b1;
    #1;
    check("arst_byte_ready", {7'b0, byte_ready}, 8'd1);
    check("arst_video", {4'b0, video}, 8'd0);
    check("arst_underflow", {7'b0, underflow}, 8'd0);
    pal_reset_model();
    @(posedge clk); #1;
    reset = 1'b0;
    bpp_sel = 2'd2;
    pix(1'b1, BORDER);
    check("post_rst_underflow", {7'b0, underflow}, 8'd1);
    push_byte(8'h5A);
    pix(1'b1, pal_m[5]);
    pix(1'b1, pal_m[10]);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cga_pixel_serializer.md
CGA_PIXEL_SERIALIZER -- requirements
Module: cga_pixel_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: byte FIFO depth; a power of two, at least 2.
REQ-002 Parameter OUT_BITS, default 4: palette entry and video output width, at least 4.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port byte_data, input, 8: VRAM pixel byte.
REQ-006 Port byte_valid, input, 1: byte_data is valid this cycle.
REQ-007 Port byte_ready, output, 1: FIFO can accept a byte.
REQ-008 Port pix_ce, input, 1: pixel-clock enable; one pixel advance per asserted cycle.
REQ-009 Port bpp_sel, input, 2: pixel depth; 0=1bpp, 1=2bpp, 2=4bpp, 3=reserved (treated as 1bpp).
REQ-010 Port display_enable, input, 1: active display region.
REQ-011 Port border_col, input, OUT_BITS: colour driven outside the active region and on underflow.
REQ-012 Port pal_we, input, 1: palette write strobe.
REQ-013 Port pal_addr, input, 4: palette write index.
REQ-014 Port pal_data, input, OUT_BITS: palette write data.
REQ-015 Port clr_underflow, input, 1: clears the sticky underflow flag.
REQ-016 Port video, output, OUT_BITS: registered pixel colour.
REQ-017 Port underflow, output, 1: sticky FIFO-starvation flag.

Function
REQ-018 The FIFO shall push byte_data when byte_valid and byte_ready are both high; byte_ready shall equal "FIFO not full".
REQ-019 If byte_valid is high while the FIFO is full, the byte shall be dropped and FIFO contents shall be unchanged.
REQ-020 Shifter state: an 8-bit shift register, a pixel counter, and a latched bpp value.
- Pixels per byte: 8 (1bpp), 4 (2bpp), 2 (4bpp).
REQ-021 On a pix_ce cycle with display_enable high and the shifter exhausted:
- the shifter shall load the FIFO head, pop it, and latch bpp_sel;
- in the same cycle it shall emit that byte's most-significant pixel.
REQ-022 On a pix_ce cycle with display_enable high and the shifter not exhausted, it shall emit the next pixel, MSB-first, using the latched bpp.
- A bpp_sel change mid-byte takes effect at the next load only.
REQ-023 Simultaneous push and pop on a full FIFO are both allowed; the count shall remain unchanged.
- A pop from an empty FIFO with a same-cycle push shall not forward the pushed byte; this counts as underflow.
REQ-024 Pixel index selection: 1bpp uses bit b; 2bpp uses bits {b+1,b}; 4bpp uses a nibble. The index is zero-extended to 4 bits and used as the palette address.
REQ-025 video shall update only on pix_ce cycles, one clk after that pix_ce: video = palette[index] when emitting, else border_col.
REQ-026 Underflow: on a pix_ce cycle with display_enable high, shifter exhausted and FIFO empty:
- underflow shall be set and video shall equal border_col;
- the shifter shall stay exhausted.
REQ-027 clr_underflow shall clear the flag next cycle; if it coincides with a new underflow event, set wins.
REQ-028 On a pix_ce cycle with display_enable low, the shifter shall discard remaining pixels (become exhausted) and video shall equal border_col; the FIFO is untouched.
REQ-029 Palette: 16 x OUT_BITS registers. A pal_we write lands at the clk edge; a same-cycle pixel lookup of that entry shall return the old value.
REQ-030 Without pix_ce, no shifter, FIFO-pop or video change occurs; pushes still proceed.

Reset
REQ-031 While reset is high:
- FIFO empty, byte_ready=1;
- shifter exhausted, latched bpp=0;
- video=0, underflow=0;
- palette[i]=i zero-extended to OUT_BITS (identity).
REQ-032 Reset mid-byte or mid-burst shall discard all buffered data; the first post-reset pix_ce with an empty FIFO shall flag underflow.

Verification
REQ-033 1bpp identity: push 0xA5, bpp_sel=0, 8 pix_ce pulses -> video sequence 1,0,1,0,0,1,0,1.
REQ-034 Depth change mid-byte: push 0xE4 and 0x1B, bpp_sel=1; after 2 pixels set bpp_sel=2 -> video 3,2,1,0 then 1,11.
REQ-035 Palette collision: write pal[5]=0xC in the same cycle as lookup of index 5 -> old 5 output; next lookup of index 5 -> 0xC.
REQ-036 Full and underflow: push 5 bytes with FIFO_DEPTH=4, no pix_ce -> 5th dropped, byte_ready=0; drain 32 pixels at 1bpp, then 1 more -> underflow=1, video=border_col.
REQ-037 Blanking: drop display_enable after 3 of 8 pixels -> border_col output, remaining 5 pixels lost, the next active pix_ce loads a new byte.
REQ-038 Async reset asserted between clk edges with the FIFO half full -> byte_ready=1, video=0, underflow=0 immediately; palette restored to identity.
